// File: rtl/shared_write_arbiter.sv
// Two-writer round-robin arbiter feeding a small FIFO with a single valid/ready output.
// Also counts the cycles where both writers compete (saturating).
module shared_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    b_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    last_grant,
  output logic [CNT_WIDTH-1:0]    conflict_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  src_e                 last_q, last_d;
  logic [CNT_WIDTH-1:0] conflict_q, conflict_d;

  logic                  full;
  logic                  push_a;
  logic                  push_b;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] wr_data;

  // Ready depends only on registered state and the valids, never on out_ready.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    a_ready = !full && (!b_valid || (last_q == SRC_B));
    b_ready = !full && (!a_valid || (last_q == SRC_A));
    push_a  = a_valid && a_ready;
    push_b  = b_valid && b_ready;
    push    = push_a || push_b;
    pop     = (count_q != '0) && out_ready;
    wr_data = push_b ? b_data : a_data;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_d     = last_q;
    conflict_d = conflict_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      last_d   = push_b ? SRC_B : SRC_A;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (a_valid && b_valid && (conflict_q != '1)) begin
      conflict_d = conflict_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= SRC_B;
      conflict_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    out_valid    = (count_q != '0);
    out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
    count        = count_q;
    last_grant   = last_q;
    conflict_cnt = conflict_q;
  end

endmodule

// File: tb/tb_shared_write_arbiter.sv
// Directed bench for shared_write_arbiter: reset, fill/drain, contention,
// full-with-pop, counter saturation and asynchronous reset mid-stream.
module tb_shared_write_arbiter;

  logic       clk;
  logic       reset;
  logic       a_valid;
  logic [3:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [3:0] b_data;
  logic       b_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [2:0] count;
  logic       last_grant;
  logic [7:0] conflict_cnt;

  int checks   = 0;
  int failures = 0;

  shared_write_arbiter #(
    .DATA_WIDTH(4),
    .DEPTH     (4),
    .CNT_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_valid     (a_valid),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .last_grant  (last_grant),
    .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; everything after this runs 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both valids high: nothing may leak through, no conflicts counted.
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 4'd1; b_data = 4'd2; out_ready = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    step();
    step();
    chk("rst_hold_count", 32'(count), 32'd0);
    chk("rst_hold_conflict", 32'(conflict_cnt), 32'd0);
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("rel_count", 32'(count), 32'd0);

    // Single-source fill with the consumer stalled.
    a_valid = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      a_data = 4'(i);
      #1;
      chk("fill_a_ready", 32'(a_ready), 32'd1);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_head", 32'(out_data), 32'd1);
    end
    chk("fill_last_grant", 32'(last_grant), 32'd0);
    a_data = 4'd5;
    #1;
    chk("full_a_ready", 32'(a_ready), 32'd0);
    step();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_head", 32'(out_data), 32'd1);

    // Full with pop: ready does not anticipate the pop.
    out_ready = 1'b1;
    #1;
    chk("full_pop_a_ready", 32'(a_ready), 32'd0);
    step();
    chk("pop_count", 32'(count), 32'd3);
    chk("pop_head", 32'(out_data), 32'd2);
    chk("pop_a_ready", 32'(a_ready), 32'd1);
    step();
    chk("pushpop_count", 32'(count), 32'd3);
    chk("pushpop_head", 32'(out_data), 32'd3);
    a_valid = 1'b0;
    step();
    chk("drain_head4", 32'(out_data), 32'd4);
    step();
    chk("drain_head5", 32'(out_data), 32'd5);
    step();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_data", 32'(out_data), 32'd0);

    // A lone B push flips the grant so the next contention starts with A.
    b_valid = 1'b1; b_data = 4'd9;
    #1;
    chk("lone_b_ready", 32'(b_ready), 32'd1);
    step();
    chk("lone_b_head", 32'(out_data), 32'd9);
    chk("lone_b_last", 32'(last_grant), 32'd1);
    b_valid = 1'b0;
    step();
    chk("lone_b_drain", 32'(count), 32'd0);

    // Contention with a free-running consumer: A,B,A,B.
    a_valid = 1'b1; a_data = 4'd6; b_valid = 1'b1; b_data = 4'd7;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      chk("cont_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("cont_head", 32'(out_data), (i % 2 == 0) ? 32'd6 : 32'd7);
      chk("cont_count", 32'(count), 32'd1);
      chk("cont_conflict", 32'(conflict_cnt), 32'(i + 1));
      chk("cont_last", 32'(last_grant), (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // Saturation: 4 + 300 conflicts clamp at 255, FIFO clamps at 4.
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      step();
    end
    chk("sat_conflict", 32'(conflict_cnt), 32'd255);
    chk("sat_count", 32'(count), 32'd4);
    chk("sat_a_ready", 32'(a_ready), 32'd0);
    chk("sat_b_ready", 32'(b_ready), 32'd0);
    step();
    chk("sat_hold", 32'(conflict_cnt), 32'd255);

    // Clear, then buffer three A words so last_grant=0.
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("clr_conflict", 32'(conflict_cnt), 32'd0);
    a_valid = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      a_data = 4'(4'hA + i);
      step();
    end
    a_valid = 1'b0;
    #1;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_last", 32'(last_grant), 32'd0);
    chk("pre_rst_head", 32'(out_data), 32'hA);

    // Asynchronous reset between edges.
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_last", 32'(last_grant), 32'd1);
    reset = 1'b0;
    a_valid = 1'b1; a_data = 4'd3; b_valid = 1'b1; b_data = 4'd5;
    #1;
    chk("post_rst_a_ready", 32'(a_ready), 32'd1);
    chk("post_rst_b_ready", 32'(b_ready), 32'd0);
    step();
    chk("post_rst_head", 32'(out_data), 32'd3);
    chk("post_rst_last", 32'(last_grant), 32'd0);
    chk("post_rst_conflict", 32'(conflict_cnt), 32'd1);

    a_valid = 1'b0; b_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_write_arbiter.md
Name: shared_write_arbiter

Overview:
- Upstream stage for a register or consumer that has two competing writers (the shared-register hazard pattern).
- Replaces the two-always-block race with deterministic round-robin arbitration between sources A and B.
- Serialises granted writes into a small FIFO and presents them on one valid/ready output stream.
- Also counts arbitration conflicts, so scheduling and ordering tests can check results against a reference count.

Parameters:
DATA_WIDTH, 4, width of each data word
DEPTH, 4, FIFO entries; power of two, at least 2
CNT_WIDTH, 8, width of saturating conflict counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
a_valid  input  1  source A has a word
a_data  input  DATA_WIDTH  source A word
a_ready  output  1  source A word accepted this cycle when a_valid is also high
b_valid  input  1  source B has a word
b_data  input  DATA_WIDTH  source B word
b_ready  output  1  source B word accepted this cycle when b_valid is also high
out_valid  output  1  FIFO head valid
out_data  output  DATA_WIDTH  FIFO head word; 0 when empty
out_ready  input  1  downstream consumes head
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
last_grant  output  1  0 = last accepted word came from A, 1 = from B
conflict_cnt  output  CNT_WIDTH  cycles with a_valid and b_valid both high, saturating

Behaviour:
- Reset is asynchronous and active-high. It forces the following immediately, with no clock needed:
  - rd_ptr = wr_ptr = 0 and count = 0.
  - out_valid = 0 and out_data = 0.
  - last_grant = 1, so A wins the first contention.
  - conflict_cnt = 0.
  - FIFO storage is not reset.
- Outputs a_ready and b_ready are combinational from the current state and the valids:
  - full = (count == DEPTH).
  - a_ready = !full && (!b_valid || last_grant == 1).
  - b_ready = !full && (!a_valid || last_grant == 0).
  - At most one of a_ready/b_ready is high while both valids are high.
  - A lone valid source gets ready whenever the FIFO is not full.
- Push:
  - A push happens on the clock edge where (a_valid && a_ready) or (b_valid && b_ready).
  - The granted data is written at wr_ptr, wr_ptr increments modulo DEPTH, and last_grant updates to the granted source.
  - last_grant does not change on cycles with no push.
- Pop:
  - A pop happens on the clock edge where out_valid && out_ready; rd_ptr increments modulo DEPTH.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else 0.
- Latency: a word accepted at edge N is visible at out_data/out_valid after edge N, i.e. 1 cycle. No bypass path exists from input to output.
- Occupancy: count(next) = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - When full, no push occurs even if a pop happens in the same cycle; ready does not look ahead at out_ready.
- Empty: a pop is impossible because out_valid is 0; out_ready is ignored.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count only.
- conflict_cnt increments on every edge where a_valid && b_valid, regardless of full. It holds at 2^CNT_WIDTH-1 once there.
- Ordering: the FIFO output order equals the acceptance order. Words from the same source are never reordered.
- Reset mid-operation discards all buffered words. The first post-reset contention is granted to A.
- Purely registered state; no combinational loop. out_ready does not affect a_ready or b_ready.

Test Plan:
1. Reset values: assert reset for 2 cycles with the valids high, then release → during reset count=0, out_valid=0, out_data=0, last_grant=1, conflict_cnt=0.
2. Single-source fill, out_ready=0: A sends 1,2,3,4,5 → 1..4 accepted on consecutive edges and count=4. a_ready drops with 5 held. Raising out_ready yields 1,2,3,4 in order, then 5 is accepted.
3. Contention, both valids held high, out_ready=1 → accept order A,B,A,B. Output is a_data,b_data alternating, 1 cycle after each accept. conflict_cnt increments by 1 per cycle.
4. Full with simultaneous pop: count=4, a_valid=1, out_ready=1 → a_ready=0 that cycle. After the edge count=3. The next edge pushes and pops, and count stays 3.
5. Saturation: hold a_valid=b_valid=1 with out_ready=0 for 300 cycles → conflict_cnt=255 and holds there; count=4 with no overflow.
6. Reset mid-stream: 3 words buffered and last_grant=0, pulse reset asynchronously between edges → out_valid falls immediately, count=0. The next contention grants A.
